// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned ITER_LAST = WIDTH_DEF - 1;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 Booth step (multiply) or restoring step (divide).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             op_i,
  input  logic [WIDTH:0]   hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             booth_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             booth_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    m_ext   = {m_i[WIDTH-1], m_i};
    sum     = hi_i;
    shifted = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
    trial   = shifted - {1'b0, m_i};
    hi_o    = hi_i;
    lo_o    = lo_i;
    booth_o = 1'b0;
    if (op_i == OP_MUL) begin
      case ({lo_i[0], booth_i})
        2'b01:   sum = hi_i + m_ext;
        2'b10:   sum = hi_i - m_ext;
        default: sum = hi_i;
      endcase
      // Arithmetic shift of {P_hi, P_lo, booth}; lo[0] becomes the next Booth bit
      {hi_o, lo_o, booth_o} = {sum[WIDTH], sum, lo_i};
    end else begin
      if (!trial[WIDTH]) begin
        hi_o = trial;
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted;
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/seq_muldiv_unit.sv
// Iterative signed multiply/divide feeding the Z register pair; FSM, operand capture and sign fixup.
module seq_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] Ydata,
  input  logic [WIDTH-1:0] BusMuxOut,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] ZhighdataOut,
  output logic [WIDTH-1:0] ZlowdataOut
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic             sa_q;
  logic             sb_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             booth_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] zhi_q;
  logic [WIDTH-1:0] zlo_q;

  logic [WIDTH:0]   hi_d;
  logic [WIDTH-1:0] lo_d;
  logic             booth_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Two's-complement negate of -2^WIDTH-1 yields the unsigned magnitude 0x80..0
  assign a_mag = Ydata[WIDTH-1]     ? -Ydata     : Ydata;
  assign b_mag = BusMuxOut[WIDTH-1] ? -BusMuxOut : BusMuxOut;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (op_q),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .booth_i (booth_q),
    .m_i     (m_q),
    .hi_o    (hi_d),
    .lo_o    (lo_d),
    .booth_o (booth_d)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      booth_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            op_q    <= op;
            a_q     <= Ydata;
            sa_q    <= Ydata[WIDTH-1];
            sb_q    <= BusMuxOut[WIDTH-1];
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            hi_q    <= '0;
            booth_q <= 1'b0;
            if (op == OP_MUL) begin
              lo_q    <= BusMuxOut;
              m_q     <= Ydata;
              state_q <= RUN;
            end else begin
              lo_q    <= a_mag;
              m_q     <= b_mag;
              state_q <= (BusMuxOut == '0) ? FIXUP : RUN;
            end
          end
        end
        RUN: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          booth_q <= booth_d;
          if (cnt_q == CNT_LAST) state_q <= FIXUP;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        FIXUP: begin
          if (op_q == OP_MUL) begin
            zhi_q <= hi_q[WIDTH-1:0];
            zlo_q <= lo_q;
          end else if (m_q == '0) begin
            zhi_q <= a_q;
            zlo_q <= '1;
            dbz_q <= 1'b1;
          end else begin
            zhi_q <= sa_q          ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
            zlo_q <= (sa_q ^ sb_q) ? -lo_q            : lo_q;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign div_by_zero  = dbz_q;
  assign ZhighdataOut = zhi_q;
  assign ZlowdataOut  = zlo_q;

endmodule
